util_cpack2_timestamp: RTL

//  RX-path counterpart of the TX timestamp unpacker. Sits between the ADC cpack output and the RX DMA in adc_clk.

---
 rtl/util_cpack2_timestamp_pkg.sv | 27 ++
 rtl/util_ts_sync_fifo.sv | 82 ++++++++
 rtl/util_cpack2_timestamp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/util_cpack2_timestamp_pkg.sv
// Shared constants for the RX timestamp packer: timestamp width, emitter
// state encodings and the bit layout of one FIFO entry {tag, ts, data}.
package util_cpack2_timestamp_pkg;

   localparam int TS_WIDTH = 64;

   // Emitter output-stage states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TS   = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // FIFO entry layout: data at the bottom, timestamp above it, tag on top
   localparam int DATA_LSB = 0;

   function automatic int ts_lsb(input int dw);
      return DATA_LSB + dw;
   endfunction

   function automatic int tag_bit(input int dw);
      return DATA_LSB + dw + TS_WIDTH;
   endfunction

   function automatic int entry_width(input int dw);
      return dw + TS_WIDTH + 1;
   endfunction

endpackage

// File: rtl/util_ts_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Storage is an inferred RAM
// with a registered read into a head register; the head register counts
// towards the total capacity of 2**DEPTH_LOG2 entries. A push on a full
// FIFO succeeds when a pop happens in the same cycle.
module util_ts_sync_fifo #(
   parameter int WIDTH      = 129,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [WIDTH-1:0]      head_reg;
   logic                  head_valid_reg;
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic [DEPTH_LOG2:0]   mem_occ;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  head_load;

   assign full    = (count_reg == DEPTH_CNT);
   assign empty   = !head_valid_reg;
   assign rd_data = head_reg;

   assign rd_ok     = rd_en && head_valid_reg;
   assign wr_ok     = wr_en && (!full || rd_ok);
   assign mem_occ   = count_reg - (DEPTH_LOG2 + 1)'(head_valid_reg);
   assign head_load = (mem_occ != '0) && (!head_valid_reg || rd_ok);

   // RAM write port
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Registered RAM read into the head slot
   always_ff @(posedge clk) begin
      if (head_load) begin
         head_reg <= mem[rd_ptr_reg];
      end
   end

   // Pointers, occupancy and head-valid bookkeeping
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         head_valid_reg <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
         end
         if (head_load) begin
            rd_ptr_reg     <= rd_ptr_reg + DEPTH_LOG2'(1);
            head_valid_reg <= 1'b1;
         end else if (rd_ok) begin
            head_valid_reg <= 1'b0;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/util_cpack2_timestamp.sv
// RX timestamp packer: tags every timestamp_every-th captured ADC word with
// the timestamp at capture, buffers {tag, ts, data} in a small FIFO and
// emits a 64-bit timestamp word ahead of each tagged data word.
// Optional macro UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN adds a saturating
// drop_count output, cleared by reset or a rising edge of m_axis_xfer_req.
module util_cpack2_timestamp
   import util_cpack2_timestamp_pkg::*;
#(
   parameter int NUM_OF_CHANNELS     = 4,
   parameter int SAMPLE_DATA_WIDTH   = 16,
   parameter int SAMPLES_PER_CHANNEL = 1,
   parameter int FIFO_DEPTH_LOG2     = 3,
   localparam int DW = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH * SAMPLES_PER_CHANNEL
) (
   input  logic          adc_clk,
   input  logic          reset,
   input  logic [63:0]   timestamp,
   input  logic [31:0]   timestamp_every,
   input  logic          fifo_wr_en,
   input  logic [DW-1:0] fifo_wr_data,
   output logic          fifo_wr_overflow,
   output logic          m_axis_valid,
   input  logic          m_axis_ready,
   output logic [DW-1:0] m_axis_data,
   input  logic          m_axis_xfer_req
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
   ,
   output logic [31:0]   drop_count
`endif
);

   localparam int EW     = entry_width(DW);
   localparam int TS_LSB = ts_lsb(DW);
   localparam int TAG    = tag_bit(DW);

   if (DW < TS_WIDTH) begin : g_dw_check
      $error("util_cpack2_timestamp: packed word narrower than the 64-bit timestamp");
   end

   logic [EW-1:0]   wr_entry;
   logic [EW-1:0]   head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            accept;
   logic            drop;
   logic            pop;
   logic            load;
   logic            emit_ts;
   logic            ts_pending;
   logic            new_tag;
   logic [32:0]     group_inc;
   logic            group_wrap;

   logic [31:0]     group_cnt_reg;
   logic            overflow_reg;
   logic [1:0]      state_reg;
   logic            valid_reg;
   logic [DW-1:0]   data_reg;

   // Capture side
   assign accept   = fifo_wr_en && m_axis_xfer_req && (!fifo_full || pop);
   assign drop     = fifo_wr_en && m_axis_xfer_req && fifo_full && !pop;
   assign new_tag  = (timestamp_every != 32'd0) && (group_cnt_reg == 32'd0);
   assign wr_entry = {new_tag, timestamp, fifo_wr_data};

   // Widened compare so lowering timestamp_every mid-group still wraps
   assign group_inc  = {1'b0, group_cnt_reg} + 33'd1;
   assign group_wrap = (group_inc >= {1'b0, timestamp_every});

   // Emitter side: a timestamp is pending exactly while the TS word is out
   assign ts_pending = (state_reg == ST_TS);
   assign load       = !valid_reg || m_axis_ready;
   assign emit_ts    = head[TAG] && !ts_pending;
   assign pop        = m_axis_xfer_req && load && !fifo_empty && !emit_ts;

   util_ts_sync_fifo #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk     (adc_clk),
      .reset   (reset),
      .flush   (!m_axis_xfer_req),
      .wr_en   (accept),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Group counter; a drop or an idle transfer restarts the group
   always_ff @(posedge adc_clk) begin
      if (reset || !m_axis_xfer_req || drop) begin
         group_cnt_reg <= 32'd0;
      end else if (accept) begin
         group_cnt_reg <= group_wrap ? 32'd0 : group_inc[31:0];
      end
   end

   // One-cycle pulse per dropped word
   always_ff @(posedge adc_clk) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= drop;
      end
   end

   // Registered output stage: emit pending timestamp, then the head data
   always_ff @(posedge adc_clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (!m_axis_xfer_req) begin
         state_reg <= ST_IDLE;
         valid_reg <= 1'b0;
      end else if (load) begin
         if (fifo_empty) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
         end else if (emit_ts) begin
            state_reg <= ST_TS;
            valid_reg <= 1'b1;
            data_reg  <= DW'(head[TS_LSB +: TS_WIDTH]);
         end else begin
            state_reg <= ST_DATA;
            valid_reg <= 1'b1;
            data_reg  <= head[DATA_LSB +: DW];
         end
      end
   end

   assign fifo_wr_overflow = overflow_reg;
   assign m_axis_valid     = valid_reg;
   assign m_axis_data      = data_reg;

`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
   logic        xfer_req_d_reg;
   logic [31:0] drop_count_reg;

   // Saturating drop counter, restarted at the start of each transfer
   always_ff @(posedge adc_clk) begin
      if (reset) begin
         xfer_req_d_reg <= 1'b0;
         drop_count_reg <= 32'd0;
      end else begin
         xfer_req_d_reg <= m_axis_xfer_req;
         if (m_axis_xfer_req && !xfer_req_d_reg) begin
            drop_count_reg <= 32'd0;
         end else if (drop && (drop_count_reg != 32'hFFFF_FFFF)) begin
            drop_count_reg <= drop_count_reg + 32'd1;
         end
      end
   end

   assign drop_count = drop_count_reg;
`endif

endmodule
